// File: rtl/rc4_prga_decrypt_pkg.sv
// Shared types and constants for the RC4 decrypt datapath and the key-search logic.
package rc4_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RD_I,
      LAT_I,
      RD_J,
      LAT_J,
      WR_J,
      WR_I,
      RD_F,
      LAT_F,
      WR_D,
      DONE
   } prga_state_t;

   localparam logic [7:0] ASCII_LO = 8'h61;
   localparam logic [7:0] ASCII_HI = 8'h7A;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam int         S_DEPTH  = 256;
   localparam int         S_AW     = $clog2(S_DEPTH);

endpackage

// File: rtl/rc4_prga_decrypt_char_check.sv
// Plaintext acceptance test: lowercase letter or space.
module rc4_char_check
   import rc4_pkg::*;
(
   input  logic [7:0] i_char,
   output logic       o_valid
);

   assign o_valid = ((i_char >= ASCII_LO) && (i_char <= ASCII_HI)) || (i_char == ASCII_SP);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation over the shared S memory; XORs the keystream with the
// encrypted ROM, writes plaintext to the decrypted RAM and reports whether it looks valid.
module rc4_prga_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LEN     = 32,
   parameter int MSG_AW      = 5,
   parameter int CHECK_ASCII = 1
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              done,
   output logic              key_valid,
   output logic [7:0]        s_mem_addr,
   output logic [7:0]        s_mem_data_in,
   input  logic [7:0]        s_mem_data_out,
   output logic              s_mem_write,
   output logic [MSG_AW-1:0] e_mem_addr,
   input  logic [7:0]        e_mem_data_out,
   output logic [MSG_AW-1:0] d_mem_addr,
   output logic [7:0]        d_mem_data_in,
   output logic              d_mem_write
);

   localparam logic [MSG_AW-1:0] LAST_K    = MSG_AW'(MSG_LEN - 1);
   localparam bit                CHECK_ON  = (CHECK_ASCII != 0);

   prga_state_t       r_state, w_next_state;
   logic [S_AW-1:0]   r_i, r_j, r_si, r_sj;
   logic [7:0]        r_f, r_enc;
   logic [MSG_AW-1:0] r_k;
   logic              r_key_valid;

   logic [7:0]        w_plain;
   logic              w_char_ok;
   logic              w_byte_ok;
   logic              w_last;

   assign w_plain   = r_f ^ r_enc;
   assign w_byte_ok = !CHECK_ON || w_char_ok;
   assign w_last    = (r_k == LAST_K);
   assign key_valid = r_key_valid;

   rc4_char_check u_char_check (
      .i_char  (w_plain),
      .o_valid (w_char_ok)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next_state = RD_I;
         RD_I:    w_next_state = LAT_I;
         LAT_I:   w_next_state = RD_J;
         RD_J:    w_next_state = LAT_J;
         LAT_J:   w_next_state = WR_J;
         WR_J:    w_next_state = WR_I;
         WR_I:    w_next_state = RD_F;
         RD_F:    w_next_state = LAT_F;
         LAT_F:   w_next_state = WR_D;
         WR_D:    w_next_state = (!w_byte_ok || w_last) ? DONE : RD_I;
         DONE:    if (!start) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Memory reads return data one cycle after the address, so LAT_* states capture q.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_i         <= '0;
         r_j         <= '0;
         r_k         <= '0;
         r_si        <= '0;
         r_sj        <= '0;
         r_f         <= '0;
         r_enc       <= '0;
         r_key_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_i         <= S_AW'(1);
                  r_j         <= '0;
                  r_k         <= '0;
                  r_key_valid <= 1'b0;
               end
            end
            LAT_I: begin
               r_si <= s_mem_data_out;
               r_j  <= r_j + s_mem_data_out;
            end
            LAT_J: r_sj <= s_mem_data_out;
            LAT_F: begin
               r_f   <= s_mem_data_out;
               r_enc <= e_mem_data_out;
            end
            WR_D: begin
               if (!w_byte_ok) begin
                  r_key_valid <= 1'b0;
               end else if (w_last) begin
                  r_key_valid <= 1'b1;
               end else begin
                  r_i <= r_i + S_AW'(1);
                  r_k <= r_k + MSG_AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no latches are inferred.
   always_comb begin
      done          = 1'b0;
      s_mem_addr    = '0;
      s_mem_data_in = '0;
      s_mem_write   = 1'b0;
      e_mem_addr    = '0;
      d_mem_addr    = '0;
      d_mem_data_in = '0;
      d_mem_write   = 1'b0;
      unique case (r_state)
         RD_I:  s_mem_addr = r_i;
         RD_J:  s_mem_addr = r_j;
         WR_J: begin
            s_mem_addr    = r_j;
            s_mem_data_in = r_si;
            s_mem_write   = 1'b1;
         end
         WR_I: begin
            s_mem_addr    = r_i;
            s_mem_data_in = r_sj;
            s_mem_write   = 1'b1;
         end
         RD_F: begin
            s_mem_addr = r_si + r_sj;
            e_mem_addr = r_k;
         end
         WR_D: begin
            d_mem_addr    = r_k;
            d_mem_data_in = w_plain;
            d_mem_write   = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench: two DUT instances (check off / check on) share one set of memory models.
module tb_rc4_prga_decrypt;

   localparam int MSG_LEN = 32;
   localparam int MSG_AW  = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0;
   logic sel = 1'b0;

   logic              done_a, kv_a, s_we_a, d_we_a;
   logic [7:0]        s_addr_a, s_din_a, d_din_a;
   logic [MSG_AW-1:0] e_addr_a, d_addr_a;
   logic              done_b, kv_b, s_we_b, d_we_b;
   logic [7:0]        s_addr_b, s_din_b, d_din_b;
   logic [MSG_AW-1:0] e_addr_b, d_addr_b;

   logic [7:0]        s_mem [256];
   logic [7:0]        e_mem [MSG_LEN];
   logic [7:0]        d_mem [MSG_LEN];
   logic [7:0]        s_addr_q;
   logic [MSG_AW-1:0] e_addr_q;
   logic [7:0]        s_q, e_q;
   logic              ld_s = 1'b0, ld_d = 1'b0;
   logic [7:0]        ld_d_val = 8'h00;

   logic [7:0]        ref_ks [MSG_LEN];
   logic [7:0]        ref_s  [256];
   logic [7:0]        clean_d [MSG_LEN];
   logic [7:0]        pt [MSG_LEN];

   int checks = 0;
   int errors = 0;
   int we_viol = 0;

   wire [7:0]        m_s_addr = sel ? s_addr_b : s_addr_a;
   wire [7:0]        m_s_din  = sel ? s_din_b  : s_din_a;
   wire              m_s_we   = sel ? s_we_b   : s_we_a;
   wire [MSG_AW-1:0] m_e_addr = sel ? e_addr_b : e_addr_a;
   wire [MSG_AW-1:0] m_d_addr = sel ? d_addr_b : d_addr_a;
   wire [7:0]        m_d_din  = sel ? d_din_b  : d_din_a;
   wire              m_d_we   = sel ? d_we_b   : d_we_a;

   assign s_q = s_mem[s_addr_q];
   assign e_q = e_mem[e_addr_q];

   always #5 clk = ~clk;

   rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW), .CHECK_ASCII(0)) u_dut_plain (
      .clk(clk), .reset_n(reset_n), .start(start_a), .done(done_a), .key_valid(kv_a),
      .s_mem_addr(s_addr_a), .s_mem_data_in(s_din_a), .s_mem_data_out(s_q), .s_mem_write(s_we_a),
      .e_mem_addr(e_addr_a), .e_mem_data_out(e_q),
      .d_mem_addr(d_addr_a), .d_mem_data_in(d_din_a), .d_mem_write(d_we_a)
   );

   rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW), .CHECK_ASCII(1)) u_dut_ascii (
      .clk(clk), .reset_n(reset_n), .start(start_b), .done(done_b), .key_valid(kv_b),
      .s_mem_addr(s_addr_b), .s_mem_data_in(s_din_b), .s_mem_data_out(s_q), .s_mem_write(s_we_b),
      .e_mem_addr(e_addr_b), .e_mem_data_out(e_q),
      .d_mem_addr(d_addr_b), .d_mem_data_in(d_din_b), .d_mem_write(d_we_b)
   );

   // Registered-address memories with unregistered read data; bench preloads go through ld_*.
   always @(posedge clk) begin
      if (ld_s) for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
      else if (m_s_we) s_mem[m_s_addr] <= m_s_din;
      if (ld_d) for (int x = 0; x < MSG_LEN; x++) d_mem[x] <= ld_d_val;
      else if (m_d_we) d_mem[m_d_addr] <= m_d_din;
      s_addr_q <= m_s_addr;
      e_addr_q <= m_e_addr;
   end

   always @(negedge clk) begin
      if ((int'(s_we_a) + int'(d_we_a) + int'(s_we_b) + int'(d_we_b)) > 1) we_viol++;
   end

   task automatic load_mems(input logic [7:0] dfill);
      @(negedge clk);
      ld_s = 1'b1; ld_d = 1'b1; ld_d_val = dfill;
      @(negedge clk);
      ld_s = 1'b0; ld_d = 1'b0;
   endtask

   task automatic rc4_model();
      logic [7:0] ms [256];
      logic [7:0] i, j, t;
      for (int x = 0; x < 256; x++) ms[x] = 8'(x);
      i = 8'd0; j = 8'd0;
      for (int k = 0; k < MSG_LEN; k++) begin
         i = i + 8'd1;
         j = j + ms[i];
         t = ms[i]; ms[i] = ms[j]; ms[j] = t;
         ref_ks[k] = ms[8'(ms[i] + ms[j])];
      end
      for (int x = 0; x < 256; x++) ref_s[x] = ms[x];
   endtask

   task automatic test_reset();
      checks++;
      if ({done_a, kv_a, done_b, kv_b} !== 4'b0) begin
         errors++; $display("FAIL reset_status got %b want 0000", {done_a, kv_a, done_b, kv_b});
      end
      checks++;
      if ({s_addr_a, s_din_a, s_we_a, e_addr_a, d_addr_a, d_din_a, d_we_a,
           s_addr_b, s_din_b, s_we_b, e_addr_b, d_addr_b, d_din_b, d_we_b} !== '0) begin
         errors++; $display("FAIL reset_mem_ports got nonzero want all zero");
      end
      @(negedge clk); reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({done_a, kv_a, s_we_a, d_we_a, s_addr_a, done_b, kv_b, s_we_b, d_we_b, s_addr_b} !== '0) begin
         errors++; $display("FAIL post_reset_idle got nonzero outputs want zero");
      end
   endtask

   task automatic test_plain_identity();
      int cyc, bad;
      load_mems(8'h00);
      for (int x = 0; x < MSG_LEN; x++) e_mem[x] = 8'h00;
      sel = 1'b0;
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      cyc = 1;
      while (!done_a && cyc < 400) begin
         @(posedge clk); #1; cyc++;
         if (cyc == 19) begin
            checks++;
            if (s_mem[2] !== 8'h03 || s_mem[3] !== 8'h02) begin
               errors++; $display("FAIL swap_byte1 got s2=%h s3=%h want 03 02", s_mem[2], s_mem[3]);
            end
         end
         if (cyc == 28) begin
            checks++;
            if (s_mem[3] !== 8'h05 || s_mem[5] !== 8'h02) begin
               errors++; $display("FAIL swap_byte2 got s3=%h s5=%h want 05 02", s_mem[3], s_mem[5]);
            end
         end
         // Start pulse while busy must be ignored.
         if (cyc == 40) start_a = 1'b1;
         if (cyc == 41) start_a = 1'b0;
      end
      checks++;
      if (cyc !== 289) begin errors++; $display("FAIL plain_done_cycle got %0d want 289", cyc); end
      checks++;
      if (kv_a !== 1'b1) begin errors++; $display("FAIL plain_key_valid got %b want 1", kv_a); end
      checks++;
      if (d_mem[0] !== 8'h02 || d_mem[1] !== 8'h05 || d_mem[2] !== 8'h07) begin
         errors++; $display("FAIL plain_d012 got %h %h %h want 02 05 07", d_mem[0], d_mem[1], d_mem[2]);
      end
      bad = 0;
      for (int x = 0; x < MSG_LEN; x++) if (d_mem[x] !== ref_ks[x]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL plain_d_all got %0d wrong bytes want 0", bad); end
      bad = 0;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL plain_s_final got %0d wrong bytes want 0", bad); end
      for (int x = 0; x < MSG_LEN; x++) clean_d[x] = d_mem[x];
      repeat (2) @(posedge clk);
   endtask

   task automatic test_ascii_pass_hold_start();
      int cyc, bad;
      load_mems(8'h00);
      for (int x = 0; x < MSG_LEN; x++) begin
         pt[x] = (x < 3 || (x % 2) == 0) ? 8'h61 : 8'h20;
         e_mem[x] = pt[x] ^ ref_ks[x];
      end
      sel = 1'b1;
      @(negedge clk); start_b = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      while (!done_b && cyc < 400) begin
         @(posedge clk); #1; cyc++;
      end
      checks++;
      if (cyc !== 289) begin errors++; $display("FAIL ascii_done_cycle got %0d want 289", cyc); end
      checks++;
      if (kv_b !== 1'b1) begin errors++; $display("FAIL ascii_key_valid got %b want 1", kv_b); end
      checks++;
      if (d_mem[0] !== 8'h61 || d_mem[1] !== 8'h61 || d_mem[2] !== 8'h61) begin
         errors++; $display("FAIL ascii_d012 got %h %h %h want 61 61 61", d_mem[0], d_mem[1], d_mem[2]);
      end
      bad = 0;
      for (int x = 0; x < MSG_LEN; x++) if (d_mem[x] !== pt[x]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ascii_d_all got %0d wrong bytes want 0", bad); end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (done_b !== 1'b1 || s_we_b !== 1'b0 || d_we_b !== 1'b0 || s_addr_b !== 8'h00) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL hold_start_no_restart got %0d bad cycles want 0", bad); end
      start_b = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done_b !== 1'b0 || kv_b !== 1'b1) begin
         errors++; $display("FAIL idle_after_done got done=%b kv=%b want 0 1", done_b, kv_b);
      end
   endtask

   task automatic test_ascii_abort();
      int cyc, bad;
      load_mems(8'hAA);
      for (int x = 0; x < MSG_LEN; x++) e_mem[x] = 8'h00;
      sel = 1'b1;
      @(negedge clk); start_b = 1'b1;
      @(posedge clk); #1; start_b = 1'b0;
      cyc = 1;
      while (!done_b && cyc < 400) begin
         @(posedge clk); #1; cyc++;
      end
      checks++;
      if (cyc !== 10) begin errors++; $display("FAIL abort_done_cycle got %0d want 10", cyc); end
      checks++;
      if (kv_b !== 1'b0) begin errors++; $display("FAIL abort_key_valid got %b want 0", kv_b); end
      checks++;
      if (d_mem[0] !== 8'h02) begin errors++; $display("FAIL abort_d0 got %h want 02", d_mem[0]); end
      bad = 0;
      for (int x = 1; x < MSG_LEN; x++) if (d_mem[x] !== 8'hAA) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL abort_d_untouched got %0d changed bytes want 0", bad); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_midrun_reset();
      int cyc, bad;
      load_mems(8'h00);
      for (int x = 0; x < MSG_LEN; x++) e_mem[x] = 8'h00;
      sel = 1'b0;
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      cyc = 1;
      while (cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      checks++;
      if (s_we_a !== 1'b1) begin errors++; $display("FAIL byte5_wr_j got s_we=%b want 1", s_we_a); end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({s_we_a, d_we_a, s_addr_a, s_din_a, done_a, kv_a} !== '0) begin
         errors++; $display("FAIL async_reset got we=%b addr=%h done=%b kv=%b want all 0",
                            s_we_a, s_addr_a, done_a, kv_a);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({s_we_a, d_we_a, s_addr_a, done_a, kv_a} !== '0) begin
         errors++; $display("FAIL after_reset_idle got nonzero outputs want zero");
      end
      load_mems(8'h00);
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      cyc = 1;
      while (!done_a && cyc < 400) begin
         @(posedge clk); #1; cyc++;
      end
      checks++;
      if (cyc !== 289 || kv_a !== 1'b1) begin
         errors++; $display("FAIL rerun_done got cycle=%0d kv=%b want 289 1", cyc, kv_a);
      end
      bad = 0;
      for (int x = 0; x < MSG_LEN; x++) if (d_mem[x] !== clean_d[x]) bad++;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rerun_match got %0d differing bytes want 0", bad); end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rc4_model();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_plain_identity();
      test_ascii_pass_hold_start();
      test_ascii_abort();
      test_midrun_reset();
      checks++;
      if (we_viol != 0) begin
         errors++; $display("FAIL one_write_enable got %0d cycles with >1 enable want 0", we_viol);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
